// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM encodings
// and a one-hot helper.
package rr_arbiter8_pkg;

    localparam int N        = 8;
    localparam int IDXW     = 3;
    localparam int HOLD_MAX = 15;
    localparam int CNTW     = 4;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter8_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping 7 -> 0.
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic            any,
    output logic [IDXW-1:0] idx
);

    logic [N-1:0]    rot;
    logic [IDXW-1:0] enc;

    // Rotate right by ptr so that bit 0 of rot is the highest-priority requester.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[IDXW'(i) + ptr];
        end
    end

    always_comb begin
        enc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = IDXW'(i);
            end
        end
    end

    assign any = |req;
    assign idx = enc + ptr;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant,
// release on done / request drop / hold timeout, and a mandatory idle gap.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    logic            state;
    logic [IDXW-1:0] ptr;
    logic [CNTW-1:0] cnt;

    logic            pick_any;
    logic [IDXW-1:0] pick_idx;

    logic            owner_dropped;
    logic            hold_expired;
    logic            release_now;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // done and request-drop win over the counter, so timeout only flags a pure expiry.
    assign owner_dropped = ~req[gnt_idx] | done;
    assign hold_expired  = (cnt == CNTW'(HOLD_MAX - 1));
    assign release_now   = owner_dropped | hold_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt     <= onehot(pick_idx);
                        gnt_idx <= pick_idx;
                        cnt     <= '0;
                        state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        gnt     <= '0;
                        ptr     <= gnt_idx + IDXW'(1);
                        cnt     <= '0;
                        timeout <= ~owner_dropped;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_valid = |gnt;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_idx_match : assert property (@(posedge clk) disable iff (rst)
        gnt_valid |-> (gnt == onehot(gnt_idx)));
    a_state_match : assert property (@(posedge clk) disable iff (rst)
        (state == ST_GRANT) == gnt_valid);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic against a
// behavioural owner/pointer model, and an exhaustive sweep of rr_pick8.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    logic [7:0] p_req;
    logic [2:0] p_ptr;
    logic       p_any;
    logic [2:0] p_idx;

    int compared;
    int mismatched;

    int m_owner;
    int m_ptr;
    int m_held;
    int m_idx;
    bit m_to;

    rr_arbiter8 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    rr_pick8 u_pick_dut (
        .req (p_req),
        .ptr (p_ptr),
        .any (p_any),
        .idx (p_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got time limit expired, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requester at or after start, wrapping; -1 when none.
    function automatic int searchFrom(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    function automatic void modelReset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_idx   = 0;
        m_to    = 0;
    endfunction

    // One clock of the arbiter rules, in terms of owner and tenure length.
    function automatic void modelStep(input logic [7:0] r, input logic d);
        m_to = 0;
        if (m_owner < 0) begin
            int p;
            p = searchFrom(r, m_ptr);
            if (p >= 0) begin
                m_owner = p;
                m_idx   = p;
                m_held  = 1;
            end
        end else if (!r[m_owner] || d || m_held == 15) begin
            m_to    = r[m_owner] && !d;
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
        end else begin
            m_held++;
        end
    endfunction

    task automatic checkAll();
        logic [7:0] eg;
        eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        checkOutput("gnt", 32'(gnt), 32'(eg));
        checkOutput("gnt_idx", 32'(gnt_idx), 32'(m_idx));
        checkOutput("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        checkOutput("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        modelStep(r, d);
        #1;
        checkAll();
    endtask

    task automatic doReset();
        req  = 8'h00;
        done = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst = 1'b0;
    endtask

    int hi_cnt;
    int to_cnt;
    int seq;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst  = 1'b0;
        req  = 8'h00;
        done = 1'b0;
        p_req = 8'h00;
        p_ptr = 3'd0;
        modelReset();

        // rr_pick8 exhaustive sweep
        for (int pt = 0; pt < 8; pt++) begin
            for (int rq = 0; rq < 256; rq++) begin
                p_ptr = 3'(pt);
                p_req = 8'(rq);
                #1;
                checkOutput("pick_any", 32'(p_any), 32'(rq != 0));
                if (rq != 0) checkOutput("pick_idx", 32'(p_idx), 32'(searchFrom(8'(rq), pt)));
            end
        end

        // Reset and single requester
        doReset();
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'b0000_0100, 1'b0);
        checkOutput("single_gnt", 32'(gnt), 32'h04);
        checkOutput("single_idx", 32'(gnt_idx), 32'd2);
        applyStimulus(8'h00, 1'b0);
        checkOutput("single_drop", 32'(gnt_valid), 32'd0);
        applyStimulus(8'hF0, 1'b0);
        checkOutput("ptr_after_drop", 32'(gnt_idx), 32'd4);
        applyStimulus(8'h00, 1'b0);

        // Round-robin rotation with done in each first grant cycle
        doReset();
        seq = 0;
        for (int k = 0; k < 18; k++) begin
            applyStimulus(8'hFF, (m_owner >= 0));
            if (m_owner >= 0) begin
                checkOutput("rr_seq", 32'(gnt_idx), 32'(seq % 8));
                seq++;
            end
        end
        checkOutput("rr_count", 32'(seq), 32'd9);

        // Pointer skip and wrap: grant 5, then 6 and 7 empty
        doReset();
        applyStimulus(8'b0010_0000, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'b0010_0010, 1'b0);
        checkOutput("wrap_idx", 32'(gnt_idx), 32'd1);
        applyStimulus(8'h00, 1'b0);

        // Hold timeout
        doReset();
        hi_cnt = 0;
        to_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(8'b0000_1000, 1'b0);
            if (gnt_valid) hi_cnt++;
            if (timeout) to_cnt++;
        end
        checkOutput("hold_cycles", 32'(hi_cnt), 32'd15);
        checkOutput("timeout_pulses", 32'(to_cnt), 32'd1);
        applyStimulus(8'b0000_1000, 1'b0);
        checkOutput("regrant_idx", 32'(gnt_idx), 32'd3);
        checkOutput("regrant_valid", 32'(gnt_valid), 32'd1);
        checkOutput("timeout_cleared", 32'(timeout), 32'd0);

        // done on the last permitted hold cycle
        doReset();
        applyStimulus(8'b0000_1000, 1'b0);
        for (int k = 0; k < 14; k++) applyStimulus(8'b0000_1000, 1'b0);
        applyStimulus(8'b0000_1000, 1'b1);
        checkOutput("simul_release", 32'(gnt_valid), 32'd0);
        checkOutput("simul_timeout", 32'(timeout), 32'd0);

        // Async reset mid-grant
        doReset();
        applyStimulus(8'b0000_0100, 1'b0);
        applyStimulus(8'b0000_0100, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async_gnt", 32'(gnt), 32'd0);
        checkOutput("async_valid", 32'(gnt_valid), 32'd0);
        checkOutput("async_idx", 32'(gnt_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h80, 1'b0);
        checkOutput("post_reset_idx", 32'(gnt_idx), 32'd7);
        applyStimulus(8'h00, 1'b0);

        // Random traffic with sticky requests so timeouts also occur
        doReset();
        begin
            logic [7:0] r;
            r = 8'h00;
            for (int k = 0; k < 800; k++) begin
                if ($urandom_range(7, 0) == 0) r = 8'($urandom);
                if ($urandom_range(40, 0) == 0) r = 8'h00;
                applyStimulus(r, ($urandom_range(9, 0) == 0));
                checkOutput("onehot", 32'($onehot0(gnt)), 32'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream resource, such as an 8-to-3 encoder datapath or a bus slot, between 8 requesters.
- Issues a registered one-hot grant plus its 3-bit binary index.
- Holds each grant until release, then rotates priority so that no requester starves.
- Sits between the requester bank and the shared encoder/datapath; a hold timeout bounds any single tenure.

Parameters:
- N, 8, number of requesters; fixed at 8 in this revision.
- IDXW, 3, width of the grant index; equals log2(N).
- HOLD_MAX, 15, maximum cycles a grant may be held before forced release; legal range 1..15.
- CNTW, 4, width of the hold counter; must hold HOLD_MAX.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request lines, level-sensitive; bit i = requester i.
- done  input  1  single-cycle pulse from the current owner ending its tenure.
- gnt  output  8  one-hot grant, registered; all zeros when idle.
- gnt_idx  output  3  binary index of the granted requester; holds its last value when idle.
- gnt_valid  output  1  high while any grant is active; equals |gnt.
- timeout  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - Priority pointer ptr=0; hold counter cnt=0.
- Reset mid-grant drops gnt immediately, without waiting for a clock edge.
- IDLE state:
  - If req != 0, pick the first set bit at or after ptr, searching ptr, ptr+1, ..., wrapping 7->0.
  - On the next edge: gnt=onehot(pick), gnt_idx=pick, gnt_valid=1, cnt=0, state -> GRANT.
  - Latency from req assertion in IDLE to gnt is 1 cycle.
- GRANT state:
  - cnt increments by 1 each cycle.
  - Release when req[gnt_idx]==0 OR done==1 OR cnt==HOLD_MAX-1.
  - On release: gnt=0, gnt_valid=0, ptr=(gnt_idx+1) mod 8, state -> IDLE.
  - timeout=1 for that one cycle only when the release was caused solely by the counter.
- Simultaneous release causes: done or req-drop take precedence, so no timeout pulse.
- Mandatory idle gap: after every release, gnt is 0 for at least 1 cycle before the next grant. This gives the shared datapath a turnaround cycle.
- Requests arriving during GRANT are not considered until IDLE.
- Changes on other req bits during GRANT are ignored.
- Pointer wrap: when gnt_idx=7, ptr becomes 0.
- Invariant: gnt is always zero or exactly one-hot.
- done while in IDLE is ignored.
- Only the pointer rotates on release. There is no starvation: with all 8 requesting and each holding 1 cycle, grants go 0,1,...,7,0 with a gap cycle between each.

Decomposition:
- Shared include arb_defs.vh:
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - N, IDXW and HOLD_MAX defaults.
- Sub-module rr_pick8 (combinational):
  - Inputs: req[7:0], ptr[2:0]. Outputs: any, idx[2:0].
  - Rotates req right by ptr, priority-encodes the lowest set bit, then adds ptr mod 8.
  - Must be verified standalone with exhaustive ptr x req.
- rr_arbiter8 holds the FSM, pointer, counter and output registers.

Test Plan:
- Reset and single requester:
  - Stimulus: assert rst, release; req=8'b00000100 at cycle 2.
  - Required: gnt=8'b00000100, gnt_idx=3'd2, gnt_valid=1 at cycle 3.
  - Drop req: gnt=0 next cycle; ptr=3.
- Round-robin rotation:
  - Stimulus: req=8'hFF constant; each owner pulses done 1 cycle after grant.
  - Required: gnt_idx sequence 0,1,2,...,7,0 with exactly one idle cycle between grants.
- Pointer skip and wrap:
  - Stimulus: ptr=6 (after granting 5); req=8'b00100010.
  - Required: grant idx 1, since 6 and 7 are clear and the search wraps past 0.
- Hold timeout:
  - Stimulus: req=8'b00001000 held high, no done.
  - Required: gnt held exactly 15 cycles, then dropped with timeout=1 for one cycle.
  - Required: regrant to idx 3 after the gap, since it is the only requester.
- Simultaneous done and timeout:
  - Stimulus: done pulsed on the cycle where cnt==14.
  - Required: release with timeout=0.
- Async reset mid-grant:
  - Stimulus: rst asserted between clock edges during GRANT.
  - Required: gnt=0, gnt_valid=0, gnt_idx=0 immediately.
  - Required: after release, req=8'h80 yields idx 7 after 1 cycle (ptr restored to 0).
